hamming_scrub_ctrl: RTL
=======================

# hamming_scrub_ctrl

Controller that owns the single SEC-DED Hamming encoder/decoder for an ECC-protected 8-bit-data memory and shares it between host accesses and a background scrubber. It encodes host writes into 13-bit codewords, decodes and corrects host reads, and periodically walks the memory, writing back corrected codewords on single-bit errors and flagging double-bit errors. It sits between the host bus and the memory macro.

## Interface
- ADDR_W, 8, memory address width (depth 2^ADDR_W)
- SCRUB_INTERVAL, 1024, cycles between scrub operations (>= 2)
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- host_req  in  1  host access request, held until host_gnt
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  8  host write data
- host_gnt  out  1  one-cycle pulse: request accepted
- host_rvalid  out  1  one-cycle pulse: host_rdata valid
- host_rdata  out  8  corrected read data
- host_err_single / host_err_double  out  1 each  status qualified by host_rvalid
- mem_req  out  1  one-cycle memory command strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  13  codeword
- mem_rvalid  in  1  read data return strobe, >= 1 cycle after read mem_req
- mem_rdata  in  13  read codeword
- scrub_en  in  1  enables interval timer
- scrub_busy  out  1  scrub sequence in progress
- sec_count / ded_count  out  16 each  saturating corrected / uncorrectable error counts (host + scrub)
- ded_irq  out  1  one-cycle pulse on any double-bit error
- ded_addr  out  ADDR_W  address of most recent double-bit error

## Operation
- Codeword: bit 0 = overall even parity; bits 1..12 = Hamming positions; check bits at 1,2,4,8; data[0..7] at positions 3,5,6,7,9,10,11,12.
- Decode: syndrome = XOR of positions of set bits 1..12; parity = XOR of all 13 bits. syn=0,par=0: clean. par=1: single (syn=0 → bit 0 flipped); correct bit syn. syn≠0,par=0: double; data returned uncorrected.
- FSM: IDLE, HOST_RD_WAIT, SCRUB_RD_WAIT, SCRUB_WB.
- IDLE: host_req → host_gnt and mem_req next cycle; write returns to IDLE, read → HOST_RD_WAIT. Else if scrub_pending → mem read of scrub_addr, → SCRUB_RD_WAIT.
- Host beats scrub on same-cycle contention; scrub stays pending. Scrub read+writeback is atomic: host_gnt held low until back in IDLE.
- HOST_RD_WAIT: on mem_rvalid, decode; next cycle host_rvalid with data/flags; → IDLE. No writeback for host reads.
- SCRUB_RD_WAIT: on mem_rvalid: clean → IDLE; single → SCRUB_WB (sec_count++); double → IDLE, ded_count++, ded_irq, ded_addr latched, no write.
- SCRUB_WB: mem_req, mem_we=1, re-encoded corrected data; → IDLE.
- scrub_addr increments on every scrub completion, wraps 2^ADDR_W-1 → 0.
- Timer counts while scrub_en; at SCRUB_INTERVAL-1 sets scrub_pending, restarts. Pending cleared when scrub read issues. Deasserting scrub_en clears timer, not pending.
- Counters saturate at 16'hFFFF.
- mem_rvalid outside a WAIT state is ignored.

## Timing
- All outputs registered. Reset: all outputs 0, FSM IDLE, timer 0, scrub_addr 0, scrub_pending 0.
- Host write: host_req sampled cycle N → host_gnt, mem_req, mem_we=1 in N+1.
- Host read: host_gnt + mem_req in N+1; mem_rvalid in M → host_rvalid in M+1.
- Scrub: read mem_req 1 cycle after pending seen in IDLE; single error writeback mem_req at M+1.
- scrub_busy high from scrub read issue through last scrub cycle.
- Reset mid-operation aborts any sequence; late mem_rvalid after reset ignored.

## Structure
- hamming_pkg: CW_W=13, syndrome width 4, position map constants, FSM state enum, encode/decode functions.
- Sub-module hamming_secded: combinational encode + decode/correct, instantiated once, shared by host and scrub paths.

## Test plan
- Host write 8'hE4 @0x10 → mem_wdata=13'h1D47 (c1..c4=1,1,0,1), mem_we=1 one cycle after request.
- Host read returning 13'h1D67 (pos5 flipped) → host_rdata=8'hE4, host_err_single=1, sec_count=1, no mem write.
- Scrub returning 13'h1D6F (pos3,5 flipped) → ded_irq pulse, ded_addr=scrub addr, ded_count=1, no writeback.
- Scrub returning 13'h1D67 → writeback 13'h1D47 at M+1; host_req during sequence stalls until IDLE.
- Host_req and scrub_pending same cycle → host served first, scrub issues next IDLE cycle; scrub_addr wraps 0xFF→0x00.
- rst_n low in SCRUB_RD_WAIT → outputs 0 next cycle; following mem_rvalid produces no response.

Source files
------------

// File: rtl/hamming_pkg.sv
// SEC-DED (13,8) code definitions shared by the scrub controller: codeword layout,
// controller states and the encode/decode functions.
package hamming_pkg;

    localparam int CW_W   = 13;
    localparam int SYN_W  = 4;
    localparam int DATA_W = 8;

    // Hamming positions holding data[0..7]; positions 1,2,4,8 carry check bits, bit 0 overall parity.
    localparam logic [3:0] DATA_POS [DATA_W] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12};

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOST_RD_WAIT,
        S_SCRUB_RD_WAIT,
        S_SCRUB_WB
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              single;
        logic              double_err;
    } dec_t;

    function automatic logic [CW_W-1:0] hamming_encode(input logic [DATA_W-1:0] data);
        logic [CW_W-1:0] cw;
        cw = '0;
        for (int i = 0; i < DATA_W; i++) cw[DATA_POS[i]] = data[i];
        for (int p = 0; p < SYN_W; p++) begin
            for (int k = 1; k < CW_W; k++) begin
                if (((k >> p) & 1) == 1 && k != (1 << p))
                    cw[4'(1 << p)] = cw[4'(1 << p)] ^ cw[4'(k)];
            end
        end
        cw[0] = ^cw[CW_W-1:1];
        return cw;
    endfunction

    function automatic dec_t hamming_decode(input logic [CW_W-1:0] cw);
        logic [SYN_W-1:0] syn;
        logic [CW_W-1:0]  fixed;
        logic             par;
        dec_t             r;
        syn = '0;
        for (int k = 1; k < CW_W; k++) if (cw[4'(k)]) syn = syn ^ 4'(k);
        par   = ^cw;
        fixed = cw;
        // A syndrome beyond position 12 with odd parity has no bit to flip; it is still reported as single.
        if (par) begin
            if (syn == '0)             fixed[0]   = ~fixed[0];
            else if (syn < 4'(CW_W))   fixed[syn] = ~fixed[syn];
        end
        for (int i = 0; i < DATA_W; i++) r.data[3'(i)] = fixed[DATA_POS[i]];
        r.single     = par;
        r.double_err = !par && (syn != '0);
        return r;
    endfunction

endpackage

// File: rtl/hamming_secded.sv
// Combinational SEC-DED encoder and decoder/corrector; one instance is shared by host and scrub paths.
module hamming_secded
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] enc_data_i,
    output logic [CW_W-1:0]   enc_cw_o,
    input  logic [CW_W-1:0]   dec_cw_i,
    output logic [DATA_W-1:0] dec_data_o,
    output logic              dec_single_o,
    output logic              dec_double_o
);

    dec_t dec;

    assign enc_cw_o     = hamming_encode(enc_data_i);
    assign dec          = hamming_decode(dec_cw_i);
    assign dec_data_o   = dec.data;
    assign dec_single_o = dec.single;
    assign dec_double_o = dec.double_err;

endmodule

// File: rtl/hamming_scrub_ctrl.sv
// ECC memory controller: encodes host writes, corrects host reads and runs a periodic
// background scrub that writes back single-bit corrections and reports double-bit errors.
module hamming_scrub_ctrl #(
    parameter int ADDR_W         = 8,
    parameter int SCRUB_INTERVAL = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [7:0]        host_rdata,
    output logic              host_err_single,
    output logic              host_err_double,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [12:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [12:0]       mem_rdata,
    input  logic              scrub_en,
    output logic              scrub_busy,
    output logic [15:0]       sec_count,
    output logic [15:0]       ded_count,
    output logic              ded_irq,
    output logic [ADDR_W-1:0] ded_addr
);
    import hamming_pkg::*;

    localparam int TIMER_W = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SCRUB_INTERVAL - 1);

    state_e              state_q;
    logic [TIMER_W-1:0]  timer_q;
    logic                scrub_pending_q;
    logic [ADDR_W-1:0]   scrub_addr_q;

    logic [DATA_W-1:0]   enc_data;
    logic [CW_W-1:0]     enc_cw;
    logic [DATA_W-1:0]   dec_data;
    logic                dec_single;
    logic                dec_double;

    // Outside IDLE the encoder re-encodes the corrected read data for scrub writeback.
    assign enc_data = (state_q == S_IDLE) ? host_wdata : dec_data;

    hamming_secded u_secded (
        .enc_data_i   (enc_data),
        .enc_cw_o     (enc_cw),
        .dec_cw_i     (mem_rdata),
        .dec_data_o   (dec_data),
        .dec_single_o (dec_single),
        .dec_double_o (dec_double)
    );

    // NOTE: every register here uses non-blocking assignment so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            timer_q         <= '0;
            scrub_pending_q <= 1'b0;
            scrub_addr_q    <= '0;
            host_gnt        <= 1'b0;
            host_rvalid     <= 1'b0;
            host_rdata      <= '0;
            host_err_single <= 1'b0;
            host_err_double <= 1'b0;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            scrub_busy      <= 1'b0;
            sec_count       <= '0;
            ded_count       <= '0;
            ded_irq         <= 1'b0;
            ded_addr        <= '0;
        end else begin
            host_gnt    <= 1'b0;
            host_rvalid <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            ded_irq     <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    // host_gnt still high means this host_req is the one just accepted.
                    if (host_req && !host_gnt) begin
                        host_gnt  <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= host_we;
                        mem_addr  <= host_addr;
                        mem_wdata <= enc_cw;
                        state_q   <= host_we ? S_IDLE : S_HOST_RD_WAIT;
                    end else if (scrub_pending_q) begin
                        mem_req         <= 1'b1;
                        mem_addr        <= scrub_addr_q;
                        scrub_busy      <= 1'b1;
                        scrub_pending_q <= 1'b0;
                        state_q         <= S_SCRUB_RD_WAIT;
                    end
                end
                S_HOST_RD_WAIT: begin
                    if (mem_rvalid) begin
                        host_rvalid     <= 1'b1;
                        host_rdata      <= dec_data;
                        host_err_single <= dec_single;
                        host_err_double <= dec_double;
                        if (dec_single && sec_count != 16'hFFFF) sec_count <= sec_count + 16'd1;
                        if (dec_double) begin
                            if (ded_count != 16'hFFFF) ded_count <= ded_count + 16'd1;
                            ded_irq  <= 1'b1;
                            ded_addr <= mem_addr;
                        end
                        state_q <= S_IDLE;
                    end
                end
                S_SCRUB_RD_WAIT: begin
                    if (mem_rvalid) begin
                        if (dec_single) begin
                            if (sec_count != 16'hFFFF) sec_count <= sec_count + 16'd1;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_wdata <= enc_cw;
                            state_q   <= S_SCRUB_WB;
                        end else begin
                            if (dec_double) begin
                                if (ded_count != 16'hFFFF) ded_count <= ded_count + 16'd1;
                                ded_irq  <= 1'b1;
                                ded_addr <= mem_addr;
                            end
                            scrub_busy   <= 1'b0;
                            scrub_addr_q <= scrub_addr_q + 1'b1;
                            state_q      <= S_IDLE;
                        end
                    end
                end
                S_SCRUB_WB: begin
                    scrub_busy   <= 1'b0;
                    scrub_addr_q <= scrub_addr_q + 1'b1;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            // Timer expiry wins over the clear from a scrub issuing in the same cycle.
            if (!scrub_en) begin
                timer_q <= '0;
            end else if (timer_q == TIMER_LAST) begin
                timer_q         <= '0;
                scrub_pending_q <= 1'b1;
            end else begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

endmodule
